frame_mode_router: RTL
======================

Name: frame_mode_router

Overview:
- Runtime-selectable stream router for the pixel pipeline. It sits between the grayscale FIFO and the final output FIFO.
- Per frame, it either forwards pixels straight to the output FIFO (bypass) or sends them through an external filter chain (padder/gaussian/sobel FIFOs) and collects that chain's results into the output FIFO.
- The mode is sampled only at frame boundaries. Every frame completes in the mode it started with.

Parameters:
- DWIDTH, 8, pixel width on every data port.
- IMG_WIDTH, 720, pixels per line.
- IMG_HEIGHT, 540, lines per frame. FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT.
- CNT_WIDTH, $clog2(FRAME_PIXELS+1), width of the pixel counters.

Ports:
- clock  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- mode_in  in  1  requested mode: 0 = bypass, 1 = filter path.
- fifo_in_rd_en  out  1  pop from the input FIFO.
- fifo_in_dout  in  DWIDTH  input FIFO head word.
- fifo_in_empty  in  1  input FIFO empty.
- path_wr_en  out  1  push into the filter-chain input FIFO.
- path_din  out  DWIDTH  filter-chain input data.
- path_full  in  1  filter-chain input FIFO full.
- path_rd_en  out  1  pop from the filter-chain output FIFO.
- path_dout  in  DWIDTH  filter-chain output head word.
- path_empty  in  1  filter-chain output FIFO empty.
- fifo_out_wr_en  out  1  push to the output FIFO.
- fifo_out_din  out  DWIDTH  output data.
- fifo_out_full  in  1  output FIFO full.
- active_mode  out  1  mode latched for the current frame.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when the last output pixel of a frame is written.

Behaviour:
- FIFO contract:
  - The head word is valid on dout whenever empty=0. rd_en=1 pops it at the clock edge.
  - wr_en=1 with full=0 writes din at the edge.
  - rd_en is never asserted while empty=1. wr_en is never asserted while full=1.
- Transfers are combinational pass-through with zero latency: din equals the popped dout in the same cycle. When wr_en=0, din is driven to 0.
- Reset values: state=IDLE, in_cnt=0, out_cnt=0, active_mode=0, busy=0, frame_done=0. All strobes are 0 while reset=1.
- Reset mid-frame abandons the frame. The block makes no attempt to drain; the surrounding FIFOs share the same reset.
- State IDLE:
  - No strobes asserted.
  - If fifo_in_empty=0: latch active_mode<=mode_in, set busy<=1, and go to BYPASS (mode 0) or FILT (mode 1).
  - mode_in is ignored at all other times.
- State BYPASS:
  - fifo_in_rd_en = fifo_out_wr_en = !fifo_in_empty & !fifo_out_full.
  - fifo_out_din = fifo_in_dout.
  - in_cnt and out_cnt both increment per transfer.
  - The transfer with out_cnt==FRAME_PIXELS-1 pulses frame_done and moves to IDLE.
  - path_* strobes stay 0.
- State FILT has two independent sub-channels, which may both fire in the same cycle:
  - Feed, while in_cnt<FRAME_PIXELS: fifo_in_rd_en = path_wr_en = !fifo_in_empty & !path_full; path_din = fifo_in_dout; in_cnt++ per transfer. When in_cnt==FRAME_PIXELS the feed channel is idle and no further input is popped.
  - Collect: path_rd_en = fifo_out_wr_en = !path_empty & !fifo_out_full; fifo_out_din = path_dout; out_cnt++ per transfer.
  - The collect transfer with out_cnt==FRAME_PIXELS-1 pulses frame_done and moves to IDLE.
  - The filter chain is required to return exactly FRAME_PIXELS words per frame.
- Leaving a frame:
  - frame_done is high only in the cycle of the final output write.
  - busy falls and both counters clear at that same edge.
- A pixel of the next frame already sitting in the input FIFO is not popped in the frame_done cycle. It is taken no earlier than the cycle after IDLE latches the new mode, so IDLE costs at least one bubble cycle per frame.
- Counters never wrap: they hold at FRAME_PIXELS until cleared on the return to IDLE.

Test Plan:
- Bypass frame: IMG 4x2, mode_in=0, input 0x00..0x07 back-to-back, no backpressure -> output 0x00..0x07 in order, 8 consecutive wr_en cycles, frame_done on the 8th, busy low the next cycle.
- Filter frame: mode_in=1, path model = FIFO returning each pixel XOR 0xFF after 5 cycles -> path receives 0x00..0x07; output receives 0xFF..0xF8; fifo_in_rd_en goes low after the 8th pop; frame_done on the 8th output write.
- Mode change mid-frame: start frame 1 in mode 1, toggle mode_in to 0 at pixel 3 -> frame 1 completes entirely via the path; frame 2 runs in bypass; active_mode changes only after frame_done.
- Backpressure: in bypass, hold fifo_out_full=1 for cycles 2-5 -> no reads or writes in those cycles, no data lost or duplicated. In filter mode, path_full=1 stalls feed while collect continues.
- Simultaneous feed/collect: path_empty=0 and path_full=0 throughout -> path_wr_en and fifo_out_wr_en both asserted in the same cycle, each counter increments by 1.
- Reset at pixel 5 of a filter frame -> next cycle: all strobes 0, busy=0, active_mode=0; the next frame restarts at in_cnt=0 and latches a fresh mode.

Source files
------------

// File: rtl/frame_mode_router_if.sv
// FIFO-side signals of the frame mode router: input FIFO, filter-chain FIFOs and output FIFO.
// The master modport is the router's view; the slave modport is the surrounding FIFOs' view.
interface frame_mode_router_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              fifo_in_rd_en;
    logic [DWIDTH-1:0] fifo_in_dout;
    logic              fifo_in_empty;
    logic              path_wr_en;
    logic [DWIDTH-1:0] path_din;
    logic              path_full;
    logic              path_rd_en;
    logic [DWIDTH-1:0] path_dout;
    logic              path_empty;
    logic              fifo_out_wr_en;
    logic [DWIDTH-1:0] fifo_out_din;
    logic              fifo_out_full;

    modport master (
        output fifo_in_rd_en, path_wr_en, path_din, path_rd_en, fifo_out_wr_en, fifo_out_din,
        input  fifo_in_dout, fifo_in_empty, path_full, path_dout, path_empty, fifo_out_full
    );

    modport slave (
        input  fifo_in_rd_en, path_wr_en, path_din, path_rd_en, fifo_out_wr_en, fifo_out_din,
        output fifo_in_dout, fifo_in_empty, path_full, path_dout, path_empty, fifo_out_full
    );
endinterface

// File: rtl/frame_mode_router.sv
// Per-frame stream router: bypass straight to the output FIFO or through the external filter chain.
// Mode is latched when a frame starts; transfers are zero-latency pass-through.
module frame_mode_router #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned CNT_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode_in,
    frame_mode_router_if.master bus,
    output logic                active_mode,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned          FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT     = CNT_WIDTH'(FRAME_PIXELS);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT     = CNT_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        FILT   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 feed_c, collect_c, last_c;

    // Transfer strobes and pass-through data; everything is quiet in IDLE and under reset.
    always_comb begin
        feed_c             = 1'b0;
        collect_c          = 1'b0;
        bus.fifo_in_rd_en  = 1'b0;
        bus.path_wr_en     = 1'b0;
        bus.path_din       = '0;
        bus.path_rd_en     = 1'b0;
        bus.fifo_out_wr_en = 1'b0;
        bus.fifo_out_din   = '0;
        if (!reset) begin
            case (state_q)
                BYPASS: begin
                    feed_c             = !bus.fifo_in_empty && !bus.fifo_out_full;
                    collect_c          = feed_c;
                    bus.fifo_in_rd_en  = feed_c;
                    bus.fifo_out_wr_en = feed_c;
                    bus.fifo_out_din   = feed_c ? bus.fifo_in_dout : '0;
                end
                FILT: begin
                    feed_c             = (in_cnt_q < FULL_CNT) && !bus.fifo_in_empty && !bus.path_full;
                    collect_c          = !bus.path_empty && !bus.fifo_out_full;
                    bus.fifo_in_rd_en  = feed_c;
                    bus.path_wr_en     = feed_c;
                    bus.path_din       = feed_c ? bus.fifo_in_dout : '0;
                    bus.path_rd_en     = collect_c;
                    bus.fifo_out_wr_en = collect_c;
                    bus.fifo_out_din   = collect_c ? bus.path_dout : '0;
                end
                default: ;
            endcase
        end
        last_c = collect_c && (out_cnt_q == LAST_CNT);
    end

    // Next state: latch mode on frame start, count transfers, release on the final output write.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_in_empty) begin
                    mode_d  = mode_in;
                    busy_d  = 1'b1;
                    state_d = mode_in ? FILT : BYPASS;
                end
            end
            default: begin
                if (feed_c)    in_cnt_d  = in_cnt_q + CNT_WIDTH'(1);
                if (collect_c) out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
                if (last_c) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
        end
    end

    assign active_mode = mode_q;
    assign busy        = busy_q;
    assign frame_done  = last_c;
endmodule
